data_mem_responder: RTL and testbench

//  Data-memory responder for the multicycle RISC-V core. It accepts load/store

---
 rtl/mem_resp_pkg.sv | 38 +++
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/mem_word_array.sv | 30 +++
 rtl/data_mem_responder.sv | 100 ++++++++++
 tb/tb_data_mem_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and request-check helper for the data-memory responder
//
// Purpose : FSM state encoding, latched operation codes, rejection codes and the
//           decode helper that turns address checks into a rejection code.
// Ports   : none (package)
package mem_resp_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'd0,
        OP_STORE    = 2'd1,
        OP_CONFLICT = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_ALIGN    = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_t;

    // Range is reported ahead of alignment and conflict; any non-NONE code rejects.
    function automatic err_t check_req(input logic in_range, input logic aligned,
                                       input logic conflict);
        if (!in_range) return ERR_RANGE;
        if (!aligned)  return ERR_ALIGN;
        if (conflict)  return ERR_CONFLICT;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core-side data-memory request/response bundle
//
// Purpose : groups the MEM-stage request and the responder's completion signals.
// Ports   : MemRead, MemWrite, dAddress, dWriteData (core -> responder)
//           dReadData, dReady, dError            (responder -> core)
// Modports: master = core side, slave = responder side.
interface data_mem_responder_if;
    import mem_resp_pkg::*;

    logic              MemRead;
    logic              MemWrite;
    logic [WORD_W-1:0] dAddress;
    logic [WORD_W-1:0] dWriteData;
    logic [WORD_W-1:0] dReadData;
    logic              dReady;
    logic              dError;

    modport master (
        output MemRead, MemWrite, dAddress, dWriteData,
        input  dReadData, dReady, dError
    );

    modport slave (
        input  MemRead, MemWrite, dAddress, dWriteData,
        output dReadData, dReady, dError
    );

endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - single-port synchronous word RAM
//
// Purpose : DEPTH_WORDS x 32-bit storage, write-enable write, registered read.
// Ports   : clk   in  1      clock
//           we    in  1      write enable
//           idx   in  IDX_W  word index (shared by read and write)
//           wdata in  32     write data
//           rdata out 32     read data, valid one cycle after idx is presented
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    IDX_W       = 10,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated data-memory responder for the multicycle core
//
// Purpose : accepts one load/store at a time, waits WAIT_CYCLES, then pulses dReady
//           for one cycle with load data or a rejection flag (dError).
// Ports   : clk  in  1   clock
//           rst  in  1   synchronous active-high reset
//           bus  slave   data_mem_responder_if (request in, response out)
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    op_t               op_q;
    err_t              err_q;

    logic [31:0]       off;
    logic [IDX_W-1:0]  idx_in;
    err_t              err_in;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign off    = bus.dAddress - ADDR_BASE;
    assign idx_in = off[IDX_W+1:2];
    assign err_in = check_req(off < SPAN, off[1:0] == 2'b00, bus.MemRead & bus.MemWrite);

    // In IDLE the RAM is addressed from the live request so that the read word is
    // already registered when RESP follows acceptance directly (WAIT_CYCLES=0).
    assign ram_idx = (state == IDLE) ? idx_in : idx_q;
    // Gating with rst drops a store whose RESP edge coincides with reset.
    assign ram_we  = (state == RESP) && (op_q == OP_STORE) && (err_q == ERR_NONE) && !rst;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= 4'd0;
            bus.dReadData <= '0;
            bus.dReady    <= 1'b0;
            bus.dError    <= 1'b0;
        end else begin
            bus.dReady <= 1'b0;
            bus.dError <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MemRead | bus.MemWrite) begin
                        idx_q    <= idx_in;
                        wdata_q  <= bus.dWriteData;
                        err_q    <= err_in;
                        op_q     <= (bus.MemRead & bus.MemWrite) ? OP_CONFLICT :
                                    bus.MemWrite                 ? OP_STORE : OP_LOAD;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RESP: begin
                    // Outputs are registered on the RESP edge, so the pulse is seen
                    // WAIT_CYCLES+1 cycles after acceptance, during the next IDLE.
                    bus.dReady    <= 1'b1;
                    bus.dError    <= (err_q != ERR_NONE);
                    bus.dReadData <= (err_q == ERR_NONE && op_q == OP_LOAD) ? ram_rdata : '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
    import mem_resp_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        req_rd, req_wr;
    logic [31:0] addr, wdata;
    int          sel;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic        o_ready, o_err;
    logic [31:0] o_data;

    always #5 clk = ~clk;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();
    data_mem_responder_if if2 ();

    assign if0.MemRead    = req_rd && (sel == 0);
    assign if0.MemWrite   = req_wr && (sel == 0);
    assign if0.dAddress   = addr;
    assign if0.dWriteData = wdata;
    assign if1.MemRead    = req_rd && (sel == 1);
    assign if1.MemWrite   = req_wr && (sel == 1);
    assign if1.dAddress   = addr;
    assign if1.dWriteData = wdata;
    assign if2.MemRead    = req_rd && (sel == 2);
    assign if2.MemWrite   = req_wr && (sel == 2);
    assign if2.dAddress   = addr;
    assign if2.dWriteData = wdata;

    data_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(1), .INIT_FILE(""))
        u_w1 (.clk(clk), .rst(rst), .bus(if0));
    data_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE(""))
        u_w0 (.clk(clk), .rst(rst), .bus(if1));
    data_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(3), .INIT_FILE(""))
        u_w3 (.clk(clk), .rst(rst2), .bus(if2));

    always_comb begin
        o_ready = if0.dReady;
        o_err   = if0.dError;
        o_data  = if0.dReadData;
        if (sel == 1) begin
            o_ready = if1.dReady;
            o_err   = if1.dError;
            o_data  = if1.dReadData;
        end else if (sel == 2) begin
            o_ready = if2.dReady;
            o_err   = if2.dError;
            o_data  = if2.dReadData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One request on DUT s; with disturb, junk is driven for one cycle of WAIT.
    task automatic do_req(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input bit disturb,
                          input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int   n;
        e.data = exp_d;
        e.err  = exp_e;
        e.lat  = (s == 0) ? 2 : (s == 1) ? 1 : 4;
        @(negedge clk);
        sel = s; req_rd = rd; req_wr = wr; addr = a; wdata = d;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        n = 1;
        if (disturb) begin
            req_rd = 1'b0; req_wr = 1'b1; addr = a + 32'd4; wdata = ~d;
            @(negedge clk);
            n = 2;
        end
        req_rd = 1'b0; req_wr = 1'b0;
        while (!o_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        chk("ready_seen", 32'(o_ready), 32'd1);
        chk("latency", 32'(n - 1), 32'(e.lat));
        chk("rdata", o_data, e.data);
        chk("error", 32'(o_err), 32'(e.err));
        @(negedge clk);
        chk("ready_pulse", 32'(o_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   seen;
        sel = 0; req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0;
        rst = 1'b1; rst2 = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_ready", 32'(o_ready), 32'd0);
            chk("reset_error", 32'(o_err), 32'd0);
            chk("reset_rdata", o_data, 32'd0);
        end
        rst = 1'b0; rst2 = 1'b0;

        // WAIT_CYCLES=1: store/load, address and conflict rejections
        do_req(0, 1'b0, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_req(0, 1'b0, 1'b1, BASE, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h1001_0002, 32'h0, 1'b0, 32'h0, 1'b1);
        do_req(0, 1'b1, 1'b0, BASE + 32'd4096, 32'h0, 1'b0, 32'h0, 1'b1);
        do_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 1'b1);
        do_req(0, 1'b1, 1'b1, BASE, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
        do_req(0, 1'b1, 1'b0, BASE, 32'h0, 1'b0, 32'h1234_5678, 1'b0);

        // WAIT_CYCLES=0: preload two words, then back-to-back loads with MemRead held
        do_req(1, 1'b0, 1'b1, BASE, 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
        do_req(1, 1'b0, 1'b1, BASE + 32'd4, 32'h5A5A_1111, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        sel = 1; req_rd = 1'b1; req_wr = 1'b0; addr = BASE;
        sb_q.push_back('{32'hA5A5_0000, 1'b0, 1});
        @(posedge clk);
        @(negedge clk);
        chk("b2b_resp_cycle", 32'(o_ready), 32'd0);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("b2b_ready0", 32'(o_ready), 32'd1);
        chk("b2b_rdata0", o_data, e.data);
        chk("b2b_error0", 32'(o_err), 32'(e.err));
        addr = BASE + 32'd4;
        sb_q.push_back('{32'h5A5A_1111, 1'b0, 1});
        @(negedge clk);
        chk("b2b_gap", 32'(o_ready), 32'd0);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("b2b_ready1", 32'(o_ready), 32'd1);
        chk("b2b_rdata1", o_data, e.data);
        chk("b2b_error1", 32'(o_err), 32'(e.err));
        req_rd = 1'b0;
        @(negedge clk);
        chk("b2b_idle", 32'(o_ready), 32'd0);

        // WAIT_CYCLES=3: reset during WAIT drops the store and clears outputs
        do_req(2, 1'b0, 1'b1, BASE + 32'd8, 32'h1111_2222, 1'b0, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
        @(negedge clk);
        sel = 2; req_wr = 1'b1; req_rd = 1'b0; addr = BASE + 32'd8; wdata = 32'h9999_9999;
        @(posedge clk);
        @(negedge clk);
        req_wr = 1'b0;
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        chk("abort_rdata", o_data, 32'd0);
        chk("abort_error", 32'(o_err), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_ready) seen++;
            @(negedge clk);
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        do_req(2, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b0, 32'h1111_2222, 1'b0);

        // Inputs changed during WAIT must not affect the latched load
        do_req(2, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b1, 32'h1111_2222, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
